// File: rtl/axi4lite_pkg.sv
// Shared types and default sizes for the AXI4-Lite register-bank slave.
package axi4lite_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 16;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle including clock and reset; A_RSTn is active-high despite its name.
interface axi4lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      A_CLK;
    logic                      A_RSTn;

    logic [ADDR_WIDTH-1:0]     AW_ADDR;
    logic                      AW_VALID;
    logic                      AW_READY;

    logic [DATA_WIDTH-1:0]     W_DATA;
    logic [DATA_WIDTH/8-1:0]   W_STRB;
    logic                      W_VALID;
    logic                      W_READY;

    logic [1:0]                B_RESP;
    logic                      B_VALID;
    logic                      B_READY;

    logic [ADDR_WIDTH-1:0]     AR_ADDR;
    logic                      AR_VALID;
    logic                      AR_READY;

    logic [DATA_WIDTH-1:0]     R_DATA;
    logic [1:0]                R_RESP;
    logic                      R_VALID;
    logic                      R_READY;

    modport slave (
        input  A_CLK, A_RSTn,
        input  AW_ADDR, AW_VALID, output AW_READY,
        input  W_DATA, W_STRB, W_VALID, output W_READY,
        output B_RESP, B_VALID, input B_READY,
        input  AR_ADDR, AR_VALID, output AR_READY,
        output R_DATA, R_RESP, R_VALID, input R_READY
    );

    modport master (
        output A_CLK, A_RSTn,
        output AW_ADDR, AW_VALID, input AW_READY,
        output W_DATA, W_STRB, W_VALID, input W_READY,
        input  B_RESP, B_VALID, output B_READY,
        output AR_ADDR, AR_VALID, input AR_READY,
        input  R_DATA, R_RESP, R_VALID, output R_READY
    );

endinterface

// File: rtl/axi4lite_regfile.sv
// Register array with a byte-strobed synchronous write port and a combinational read port.
module axi4lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [$clog2(NUM_REGS)-1:0] widx_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    input  logic [DATA_WIDTH/8-1:0]     wstrb_i,
    input  logic [$clog2(NUM_REGS)-1:0] ridx_i,
    output logic [DATA_WIDTH-1:0]       rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite slave fronting a small register bank; read and write paths run independently.
//   state  | meaning
//   R_IDLE | AR_READY high, waiting for a read address
//   R_DATA | R_VALID high, holding read data until R_READY
//   W_IDLE | collecting AW and W in any order
//   W_RESP | B_VALID high, holding response until B_READY
module axi4lite_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF
) (
    axi4lite_if.slave bus
);

    localparam int                    IDX_W      = $clog2(NUM_REGS);
    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    rd_state_t               rd_state_q;
    logic                    ar_ready_q;
    logic                    r_valid_q;
    logic [DATA_WIDTH-1:0]   r_data_q;
    resp_t                   r_resp_q;

    wr_state_t               wr_state_q;
    logic                    aw_ready_q;
    logic                    w_ready_q;
    logic                    b_valid_q;
    resp_t                   b_resp_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;

    logic                    ar_ok;
    logic                    aw_ok;
    logic                    wr_fire;
    logic                    rf_we;
    logic [DATA_WIDTH-1:0]   rf_rdata;

    assign ar_ok   = bus.AR_ADDR < ADDR_LIMIT;
    assign aw_ok   = aw_addr_q < ADDR_LIMIT;
    // Both channels latched: commit the write on this edge.
    assign wr_fire = (wr_state_q == W_IDLE) && !aw_ready_q && !w_ready_q;
    assign rf_we   = wr_fire && aw_ok;

    axi4lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk_i   (bus.A_CLK),
        .rst_i   (bus.A_RSTn),
        .we_i    (rf_we),
        .widx_i  (aw_addr_q[IDX_W+1:2]),
        .wdata_i (w_data_q),
        .wstrb_i (w_strb_q),
        .ridx_i  (bus.AR_ADDR[IDX_W+1:2]),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge bus.A_CLK) begin
        if (bus.A_RSTn) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (bus.AR_VALID && ar_ready_q) begin
                        r_data_q   <= ar_ok ? rf_rdata : '0;
                        r_resp_q   <= ar_ok ? OKAY : SLVERR;
                        r_valid_q  <= 1'b1;
                        ar_ready_q <= 1'b0;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.R_READY) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus.A_CLK) begin
        if (bus.A_RSTn) begin
            wr_state_q <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_fire) begin
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= aw_ok ? OKAY : SLVERR;
                        wr_state_q <= W_RESP;
                    end else begin
                        if (bus.AW_VALID && aw_ready_q) begin
                            aw_addr_q  <= bus.AW_ADDR;
                            aw_ready_q <= 1'b0;
                        end
                        if (bus.W_VALID && w_ready_q) begin
                            w_data_q  <= bus.W_DATA;
                            w_strb_q  <= bus.W_STRB;
                            w_ready_q <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.B_READY) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.AR_READY = ar_ready_q;
    assign bus.R_VALID  = r_valid_q;
    assign bus.R_DATA   = r_data_q;
    assign bus.R_RESP   = r_resp_q;
    assign bus.AW_READY = aw_ready_q;
    assign bus.W_READY  = w_ready_q;
    assign bus.B_VALID  = b_valid_q;
    assign bus.B_RESP   = b_resp_q;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Directed bench for axi4lite_slave: handshakes, strobes, decode errors, backpressure, reset.
module tb_axi4lite_slave;

    axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

    axi4lite_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .bus (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        ifc.A_CLK = 1'b0;
        forever #5 ifc.A_CLK = ~ifc.A_CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ifc.A_CLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead,
                             output logic [1:0] resp);
        int n;
        bit aw_pend, w_pend, aw_hs, w_hs;
        ifc.W_DATA   = data;
        ifc.W_STRB   = strb;
        ifc.W_VALID  = 1'b1;
        ifc.AW_ADDR  = addr;
        ifc.AW_VALID = (w_lead == 0);
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        n = 0;
        while ((aw_pend || w_pend) && n < 50) begin
            aw_hs = ifc.AW_VALID && ifc.AW_READY;
            w_hs  = ifc.W_VALID && ifc.W_READY;
            tick();
            n++;
            if (aw_hs) begin ifc.AW_VALID = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin ifc.W_VALID  = 1'b0; w_pend  = 1'b0; end
            if (aw_pend && !ifc.AW_VALID && n >= w_lead) ifc.AW_VALID = 1'b1;
        end
        ifc.AW_VALID = 1'b0;
        ifc.W_VALID  = 1'b0;
        check("wr_handshakes", 32'(aw_pend || w_pend), 32'd0);
        n = 0;
        while (!ifc.B_VALID && n < 20) begin
            tick();
            n++;
        end
        check("b_latency", 32'(n), 32'd1);
        resp = ifc.B_RESP;
        ifc.B_READY = 1'b1;
        tick();
        ifc.B_READY = 1'b0;
        check("b_valid_clr", 32'(ifc.B_VALID), 32'd0);
        check("aw_ready_ret", 32'(ifc.AW_READY & ifc.W_READY), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        check("ar_ready_idle", 32'(ifc.AR_READY), 32'd1);
        ifc.AR_ADDR  = addr;
        ifc.AR_VALID = 1'b1;
        tick();
        ifc.AR_VALID = 1'b0;
        n = 1;
        while (!ifc.R_VALID && n < 20) begin
            tick();
            n++;
        end
        check("r_latency", 32'(n), 32'd1);
        data = ifc.R_DATA;
        resp = ifc.R_RESP;
        ifc.R_READY = 1'b1;
        tick();
        ifc.R_READY = 1'b0;
        check("r_valid_clr", 32'(ifc.R_VALID), 32'd0);
        check("ar_ready_ret", 32'(ifc.AR_READY), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [1:0]  ws;

        ifc.A_RSTn   = 1'b1;
        ifc.AW_ADDR  = '0; ifc.AW_VALID = 1'b0;
        ifc.W_DATA   = '0; ifc.W_STRB   = '0; ifc.W_VALID = 1'b0;
        ifc.B_READY  = 1'b0;
        ifc.AR_ADDR  = '0; ifc.AR_VALID = 1'b0;
        ifc.R_READY  = 1'b0;
        tick();
        tick();
        ifc.A_RSTn = 1'b0;

        check("rst_ready", 32'({ifc.AW_READY, ifc.W_READY, ifc.AR_READY}), 32'h7);
        check("rst_valid", 32'({ifc.B_VALID, ifc.R_VALID}), 32'h0);
        check("rst_rdata", ifc.R_DATA, 32'h0);
        check("rst_resp", 32'({ifc.B_RESP, ifc.R_RESP}), 32'h0);

        axi_read(32'h0, rd, rs);
        check("rd0_data", rd, 32'h0000_0000);
        check("rd0_resp", 32'(rs), 32'd0);

        axi_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, ws);
        check("wr4_resp", 32'(ws), 32'd0);
        axi_read(32'h4, rd, rs);
        check("rd4_data", rd, 32'hDEAD_BEEF);

        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, 0, ws);
        axi_write(32'h8, 32'h1234_5678, 4'h3, 3, ws);
        check("wr8_strb_resp", 32'(ws), 32'd0);
        axi_read(32'h8, rd, rs);
        check("rd8_strb_data", rd, 32'hFFFF_5678);

        // Upper-lane-only write to exercise the other byte enables.
        axi_write(32'h8, 32'hAB00_0000, 4'h8, 0, ws);
        axi_read(32'h8, rd, rs);
        check("rd8_lane3", rd, 32'hABFF_5678);

        axi_write(32'h4, 32'h0000_0000, 4'h0, 0, ws);
        check("wr_strb0_resp", 32'(ws), 32'd0);
        axi_read(32'h4, rd, rs);
        check("rd_strb0_data", rd, 32'hDEAD_BEEF);

        axi_read(32'h40, rd, rs);
        check("rd_oob_resp", 32'(rs), 32'd2);
        check("rd_oob_data", rd, 32'h0);
        axi_write(32'h40, 32'hCAFE_F00D, 4'hF, 0, ws);
        check("wr_oob_resp", 32'(ws), 32'd2);
        axi_read(32'h0, rd, rs);
        check("wr_oob_alias", rd, 32'h0);

        axi_read(32'h3F, rd, rs);
        check("rd_last_resp", 32'(rs), 32'd0);

        // Same-index read and write on the same edge: read sees the old value.
        ifc.AW_ADDR = 32'hC; ifc.AW_VALID = 1'b1;
        ifc.W_DATA  = 32'h1111_1111; ifc.W_STRB = 4'hF; ifc.W_VALID = 1'b1;
        tick();
        ifc.AW_VALID = 1'b0; ifc.W_VALID = 1'b0;
        ifc.AR_ADDR = 32'hC; ifc.AR_VALID = 1'b1;
        tick();
        ifc.AR_VALID = 1'b0;
        check("rw_same_rvalid", 32'({ifc.R_VALID, ifc.B_VALID}), 32'h3);
        check("rw_same_rdata", ifc.R_DATA, 32'h0);
        ifc.R_READY = 1'b1; ifc.B_READY = 1'b1;
        tick();
        ifc.R_READY = 1'b0; ifc.B_READY = 1'b0;
        check("rw_same_clr", 32'({ifc.R_VALID, ifc.B_VALID}), 32'h0);
        axi_read(32'hC, rd, rs);
        check("rw_same_after", rd, 32'h1111_1111);

        // Early R_READY: response must still appear for exactly one cycle.
        ifc.R_READY = 1'b1;
        tick();
        check("early_rready_idle", 32'(ifc.R_VALID), 32'd0);
        ifc.AR_ADDR = 32'h4; ifc.AR_VALID = 1'b1;
        tick();
        ifc.AR_VALID = 1'b0;
        check("early_rready_valid", 32'(ifc.R_VALID), 32'd1);
        check("early_rready_data", ifc.R_DATA, 32'hDEAD_BEEF);
        tick();
        ifc.R_READY = 1'b0;
        check("early_rready_clr", 32'(ifc.R_VALID), 32'd0);

        ifc.AR_ADDR = 32'h4; ifc.AR_VALID = 1'b1;
        tick();
        ifc.AR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rbp_valid", 32'(ifc.R_VALID), 32'd1);
            check("rbp_data", ifc.R_DATA, 32'hDEAD_BEEF);
            check("rbp_arready", 32'(ifc.AR_READY), 32'd0);
            tick();
        end
        ifc.R_READY = 1'b1;
        tick();
        ifc.R_READY = 1'b0;
        check("rbp_done", 32'({ifc.R_VALID, ifc.AR_READY}), 32'h1);

        ifc.AW_ADDR = 32'h44; ifc.AW_VALID = 1'b1;
        ifc.W_DATA  = 32'h0BAD_F00D; ifc.W_STRB = 4'hF; ifc.W_VALID = 1'b1;
        tick();
        ifc.AW_VALID = 1'b0; ifc.W_VALID = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bbp_valid", 32'(ifc.B_VALID), 32'd1);
            check("bbp_resp", 32'(ifc.B_RESP), 32'd2);
            check("bbp_ready", 32'({ifc.AW_READY, ifc.W_READY}), 32'h0);
            tick();
        end
        ifc.B_READY = 1'b1;
        tick();
        ifc.B_READY = 1'b0;
        check("bbp_done", 32'({ifc.B_VALID, ifc.AW_READY, ifc.W_READY}), 32'h3);

        // Reset while both paths are holding a response.
        ifc.AR_ADDR = 32'h8; ifc.AR_VALID = 1'b1;
        ifc.AW_ADDR = 32'h4; ifc.AW_VALID = 1'b1;
        ifc.W_DATA  = 32'h5555_5555; ifc.W_STRB = 4'hF; ifc.W_VALID = 1'b1;
        tick();
        ifc.AR_VALID = 1'b0; ifc.AW_VALID = 1'b0; ifc.W_VALID = 1'b0;
        tick();
        check("pre_rst_valids", 32'({ifc.R_VALID, ifc.B_VALID}), 32'h3);
        ifc.A_RSTn = 1'b1;
        tick();
        ifc.A_RSTn = 1'b0;
        check("mid_rst_valids", 32'({ifc.R_VALID, ifc.B_VALID}), 32'h0);
        check("mid_rst_ready", 32'({ifc.AW_READY, ifc.W_READY, ifc.AR_READY}), 32'h7);
        check("mid_rst_rdata", ifc.R_DATA, 32'h0);
        axi_read(32'h4, rd, rs);
        check("mid_rst_reg4", rd, 32'h0);
        axi_read(32'h8, rd, rs);
        check("mid_rst_reg8", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
